wb_sharedbus: RTL and testbench

WB_SHAREDBUS -- requirements
Module: wb_sharedbus

---
 rtl/wb_sharedbus.sv | 150 +++++++++++++++
 tb/tb_wb_sharedbus.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_sharedbus.sv
// Shared-bus Wishbone interconnect: NM masters share one bus to NS slaves.
// Round-robin registered arbitration, address decode, and decode/timeout bus errors.
module wb_sharedbus #(
  parameter int                     NM       = 6,
  parameter int                     NS       = 6,
  parameter int                     S_ADDR_W = 3,
  parameter logic [NS*S_ADDR_W-1:0] S_ADDR   = {3'b110, 3'b101, 3'b100, 3'b010, 3'b001, 3'b000},
  parameter int                     TIMEOUT  = 255
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [NM*32-1:0] m_adr_i,
  input  logic [NM*32-1:0] m_dat_i,
  input  logic [NM*4-1:0]  m_sel_i,
  input  logic [NM*3-1:0]  m_cti_i,
  input  logic [NM-1:0]    m_we_i,
  input  logic [NM-1:0]    m_cyc_i,
  input  logic [NM-1:0]    m_stb_i,
  output logic [31:0]      m_dat_o,
  output logic [NM-1:0]    m_ack_o,
  output logic [NM-1:0]    m_err_o,
  output logic [31:0]      s_adr_o,
  output logic [31:0]      s_dat_o,
  output logic [3:0]       s_sel_o,
  output logic [2:0]       s_cti_o,
  output logic             s_we_o,
  output logic [NS-1:0]    s_cyc_o,
  output logic [NS-1:0]    s_stb_o,
  input  logic [NS*32-1:0] s_dat_i,
  input  logic [NS-1:0]    s_ack_i,
  output logic [NM-1:0]    grant_o
);

  localparam int MW     = (NM > 1) ? $clog2(NM) : 1;
  localparam int SW     = (NS > 1) ? $clog2(NS) : 1;
  localparam int CW_RAW = $clog2(TIMEOUT + 1);
  localparam int CW     = (CW_RAW < 8) ? 8 : ((CW_RAW > 16) ? 16 : CW_RAW);
  localparam int unsigned NMU = NM;
  localparam int unsigned NSU = NS;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t          state_q, state_d;
  logic [MW-1:0]   last_q, last_d;   // doubles as the current owner while OWNED
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            derr_q, derr_d;
  logic            derr_done_q, derr_done_d;

  logic            owned, own_cyc, own_stb;
  logic            cand_found;
  logic [MW-1:0]   cand;
  logic            hit;
  logic [SW-1:0]   hit_idx;
  logic [NS-1:0]   hit_vec;
  logic [NM-1:0]   own_onehot;
  logic            ack_own, to_err, err_own, same_grant;

  assign owned      = (state_q == OWNED);
  assign own_cyc    = owned & m_cyc_i[last_q];
  assign own_stb    = own_cyc & m_stb_i[last_q];
  assign own_onehot = NM'(1) << last_q;

  assign s_adr_o = owned ? m_adr_i[last_q*32 +: 32] : '0;
  assign s_dat_o = owned ? m_dat_i[last_q*32 +: 32] : '0;
  assign s_sel_o = owned ? m_sel_i[last_q*4 +: 4]   : '0;
  assign s_cti_o = owned ? m_cti_i[last_q*3 +: 3]   : '0;
  assign s_we_o  = owned & m_we_i[last_q];

  // Search starts just after the last owner so every requester gets a turn.
  always_comb begin
    cand_found = 1'b0;
    cand       = '0;
    for (int unsigned i = 1; i <= NMU; i++) begin
      if (!cand_found && m_cyc_i[(32'(last_q) + i) % NMU]) begin
        cand_found = 1'b1;
        cand       = MW'((32'(last_q) + i) % NMU);
      end
    end
  end

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned k = 0; k < NSU; k++) begin
      if (owned && !hit && (s_adr_o[31 -: S_ADDR_W] == S_ADDR[k*S_ADDR_W +: S_ADDR_W])) begin
        hit     = 1'b1;
        hit_idx = SW'(k);
      end
    end
  end

  assign hit_vec = hit ? (NS'(1) << hit_idx) : '0;
  assign s_cyc_o = own_cyc ? hit_vec : '0;
  assign s_stb_o = own_stb ? hit_vec : '0;
  assign m_dat_o = hit ? s_dat_i[hit_idx*32 +: 32] : '0;

  assign ack_own = own_cyc & hit & s_ack_i[hit_idx];
  assign to_err  = (TIMEOUT != 0) && own_stb && (cnt_q == CW'(TIMEOUT)) && !ack_own;
  assign err_own = (derr_q | to_err) & ~ack_own;

  assign grant_o = owned   ? own_onehot : '0;
  assign m_ack_o = ack_own ? own_onehot : '0;
  assign m_err_o = err_own ? own_onehot : '0;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (cand_found) begin
          state_d = OWNED;
          last_d  = cand;
        end
      end
      OWNED: begin
        if (!m_cyc_i[last_q]) begin
          if (cand_found) last_d = cand;
          else            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    same_grant = owned && (state_d == OWNED) && (last_d == last_q);

    if (!same_grant || !own_stb || ack_own || err_own || (TIMEOUT == 0)) cnt_d = '0;
    else                                                               cnt_d = cnt_q + 1'b1;

    // Decode error fires once per strobe assertion; the done flag blocks repeats.
    derr_d      = same_grant & own_stb & ~hit & ~derr_q & ~derr_done_q;
    derr_done_d = same_grant & own_stb & (derr_done_q | derr_q);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      last_q      <= MW'(NM - 1);
      cnt_q       <= '0;
      derr_q      <= 1'b0;
      derr_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      derr_q      <= derr_d;
      derr_done_q <= derr_done_d;
    end
  end

endmodule

// File: tb/tb_wb_sharedbus.sv
// Directed bench for wb_sharedbus: arbitration rotation, decode, decode error,
// timeout (TIMEOUT=4), ack/timeout priority and reset mid-burst.
module tb_wb_sharedbus;
  localparam int NM = 6;
  localparam int NS = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic [NM*32-1:0] m_adr, m_dat;
  logic [NM*4-1:0]  m_sel;
  logic [NM*3-1:0]  m_cti;
  logic [NM-1:0]    m_we, m_cyc, m_stb;
  logic [31:0]      m_dat_o;
  logic [NM-1:0]    m_ack_o, m_err_o, grant_o;
  logic [31:0]      s_adr_o, s_dat_o;
  logic [3:0]       s_sel_o;
  logic [2:0]       s_cti_o;
  logic             s_we_o;
  logic [NS-1:0]    s_cyc_o, s_stb_o;
  logic [NS*32-1:0] s_dat;
  logic [NS-1:0]    s_ack;

  int errors = 0;
  int checks = 0;

  wb_sharedbus #(.NM(NM), .NS(NS), .TIMEOUT(4)) dut (
    .sys_clk(clk), .sys_rst(rst),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_cti_i(m_cti),
    .m_we_i(m_we), .m_cyc_i(m_cyc), .m_stb_i(m_stb),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o),
    .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_m(input int i, input logic [31:0] adr, input logic [2:0] cti,
                       input logic cyc, input logic stb);
    m_adr[i*32 +: 32] = adr;
    m_dat[i*32 +: 32] = 32'h0;
    m_sel[i*4 +: 4]   = 4'hF;
    m_cti[i*3 +: 3]   = cti;
    m_we[i]           = 1'b0;
    m_cyc[i]          = cyc;
    m_stb[i]          = stb;
  endtask

  initial begin
    rst = 1'b1;
    m_adr = '0; m_dat = '0; m_sel = '0; m_cti = '0;
    m_we = '0; m_cyc = '0; m_stb = '0;
    s_dat = '0; s_ack = '0;
    tick(); tick();
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_stb",   32'(s_stb_o), 32'h0);
    chk("rst_cyc",   32'(s_cyc_o), 32'h0);
    chk("rst_ack",   32'(m_ack_o), 32'h0);
    chk("rst_err",   32'(m_err_o), 32'h0);
    rst = 1'b0;
    tick();

    // Single read from master 0 to slave 2, ack on the third owned cycle.
    set_m(0, 32'h4000_0010, 3'b000, 1'b1, 1'b1);
    settle();
    chk("t1_grant_pre", 32'(grant_o), 32'h0);
    tick();
    chk("t1_grant", 32'(grant_o), 32'h01);
    chk("t1_stb",   32'(s_stb_o), 32'h04);
    chk("t1_adr",   s_adr_o, 32'h4000_0010);
    chk("t1_noack", 32'(m_ack_o), 32'h0);
    tick(); tick();
    s_ack = 6'b000100;
    s_dat[2*32 +: 32] = 32'hDEAD_BEEF;
    settle();
    chk("t1_ack", 32'(m_ack_o), 32'h01);
    chk("t1_dat", m_dat_o, 32'hDEAD_BEEF);
    chk("t1_err", 32'(m_err_o), 32'h0);
    tick();
    s_ack = '0;
    set_m(0, 32'h0, 3'b000, 1'b0, 1'b0);
    settle();
    chk("t1_ack_drop", 32'(m_ack_o), 32'h0);
    tick();
    chk("t1_idle", 32'(grant_o), 32'h0);

    // Rotation between masters 0 and 1 after a fresh reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_m(0, 32'h0, 3'b000, 1'b1, 1'b0);
    set_m(1, 32'h0, 3'b000, 1'b1, 1'b0);
    tick();
    chk("rr_first0", 32'(grant_o), 32'h01);
    tick();
    chk("rr_hold0", 32'(grant_o), 32'h01);
    m_cyc[0] = 1'b0;
    tick();
    chk("rr_then1", 32'(grant_o), 32'h02);
    m_cyc[0] = 1'b1;
    tick();
    chk("rr_hold1", 32'(grant_o), 32'h02);
    m_cyc[1] = 1'b0;
    tick();
    chk("rr_back0", 32'(grant_o), 32'h01);
    m_cyc = '0;
    tick();
    chk("rr_idle", 32'(grant_o), 32'h0);

    // Unmapped address from master 1: single registered error, no slave strobe.
    set_m(1, 32'h6000_0000, 3'b000, 1'b1, 1'b1);
    tick();
    chk("de_grant", 32'(grant_o), 32'h02);
    chk("de_nostb", 32'(s_stb_o), 32'h0);
    chk("de_nocyc", 32'(s_cyc_o), 32'h0);
    chk("de_err0",  32'(m_err_o), 32'h0);
    tick();
    chk("de_err1",  32'(m_err_o), 32'h02);
    chk("de_noack", 32'(m_ack_o), 32'h0);
    tick();
    chk("de_err2",  32'(m_err_o), 32'h0);
    set_m(1, 32'h0, 3'b000, 1'b0, 1'b0);
    tick();

    // Timeout: master 2 to slave 0, never acked.
    set_m(2, 32'h0000_0000, 3'b000, 1'b1, 1'b1);
    tick();
    chk("to_grant", 32'(grant_o), 32'h04);
    chk("to_stb",   32'(s_stb_o), 32'h01);
    chk("to_c1",    32'(m_err_o), 32'h0);
    tick(); tick(); tick();
    chk("to_c4",    32'(m_err_o), 32'h0);
    tick();
    chk("to_c5",    32'(m_err_o), 32'h04);
    chk("to_stb5",  32'(s_stb_o), 32'h01);
    tick();
    chk("to_c6",    32'(m_err_o), 32'h0);
    tick(); tick(); tick();
    chk("to_c9",    32'(m_err_o), 32'h0);
    tick();
    chk("to_c10",   32'(m_err_o), 32'h04);
    set_m(2, 32'h0, 3'b000, 1'b0, 1'b0);
    tick();
    chk("to_idle",  32'(grant_o), 32'h0);

    // Master 3 to slave 1: ack on 4th cycle, then ack coinciding with timeout.
    set_m(3, 32'h2000_0000, 3'b000, 1'b1, 1'b1);
    tick();
    chk("ak_grant", 32'(grant_o), 32'h08);
    chk("ak_stb",   32'(s_stb_o), 32'h02);
    tick(); tick(); tick();
    s_ack = 6'b000010;
    s_dat[1*32 +: 32] = 32'h1234_5678;
    settle();
    chk("ak4_ack",  32'(m_ack_o), 32'h08);
    chk("ak4_err",  32'(m_err_o), 32'h0);
    chk("ak4_dat",  m_dat_o, 32'h1234_5678);
    tick();
    s_ack = '0;
    tick(); tick(); tick(); tick();
    s_ack = 6'b000010;
    settle();
    chk("akto_ack", 32'(m_ack_o), 32'h08);
    chk("akto_err", 32'(m_err_o), 32'h0);
    tick();
    s_ack = '0;
    settle();
    chk("akto_after", 32'(m_err_o), 32'h0);
    set_m(3, 32'h0, 3'b000, 1'b0, 1'b0);
    tick();

    // Reset in the middle of a master 2 incrementing burst.
    s_ack = 6'b000100;
    set_m(2, 32'h4000_0000, 3'b010, 1'b1, 1'b1);
    settle();
    chk("rb_preack", 32'(m_ack_o), 32'h0);
    tick();
    chk("rb_grant", 32'(grant_o), 32'h04);
    chk("rb_cti",   32'(s_cti_o), 32'h2);
    chk("rb_ack",   32'(m_ack_o), 32'h04);
    rst = 1'b1;
    tick();
    chk("rb_rgrant", 32'(grant_o), 32'h0);
    chk("rb_rstb",   32'(s_stb_o), 32'h0);
    chk("rb_rcyc",   32'(s_cyc_o), 32'h0);
    chk("rb_rack",   32'(m_ack_o), 32'h0);
    chk("rb_rerr",   32'(m_err_o), 32'h0);
    rst = 1'b0;
    set_m(2, 32'h0, 3'b000, 1'b0, 1'b0);
    s_ack = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
